// File: rtl/fire_layer_sequencer.sv
// ============================================================================
// Module   : fire_layer_sequencer
// Purpose  : Steps through up to eight fire-layer configurations held in a
//            local 8x21 table. For each layer it presents the layer config,
//            pulses start_o to the kernel reader, waits a settle window and
//            then waits for the compute path (and, for expand-1x1 layers,
//            the kernel reader) to report completion.
// Ports    : clk_i / rst_i               clock, sync active-high reset
//            cfg_wr_en/addr/data_i       table write port (IDLE only)
//            num_layers_i, run_i         sequence length-1 and start pulse
//            abort_i                     abandon sequence, return to IDLE
//            rd_done_i (level)           kernel reader finished the layer
//            proc_done_i (pulse)         compute path finished the layer
//            start_o                     one-cycle layer start
//            exp_1x1_en_o, one_exp1_ker_addr_limit_o, exp1_ker_depth_o,
//            layer_dimension_o           current layer configuration
//            layer_idx_o, busy_o, all_done_o  status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fire_layer_sequencer #(
  parameter int SETTLE_CYC = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_wr_en_i,
  input  logic [2:0]  cfg_wr_addr_i,
  input  logic [20:0] cfg_wr_data_i,
  input  logic [2:0]  num_layers_i,
  input  logic        run_i,
  input  logic        abort_i,
  input  logic        rd_done_i,
  input  logic        proc_done_i,
  output logic        start_o,
  output logic        exp_1x1_en_o,
  output logic [6:0]  one_exp1_ker_addr_limit_o,
  output logic [5:0]  exp1_ker_depth_o,
  output logic [6:0]  layer_dimension_o,
  output logic [2:0]  layer_idx_o,
  output logic        busy_o,
  output logic        all_done_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_SETTLE = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_t             r_state;
  state_t             w_next;
  logic [20:0]        r_tbl [8];
  logic [2:0]         r_last;
  logic [2:0]         r_idx;
  logic               r_rd_seen;
  logic               r_proc_seen;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_start;
  logic               r_exp_en;
  logic [6:0]         r_limit;
  logic [5:0]         r_depth;
  logic [6:0]         r_dim;
  logic               r_busy;
  logic               r_all_done;

  // Same-cycle inputs count toward completion, so OR them with the flags.
  logic w_rd_any;
  logic w_proc_any;
  logic w_layer_done;

  assign w_rd_any     = r_rd_seen | rd_done_i;
  assign w_proc_any   = r_proc_seen | proc_done_i;
  assign w_layer_done = (r_state == S_WAIT) && w_proc_any && (w_rd_any || !r_exp_en);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run_i) w_next = S_FETCH;
      S_FETCH:  w_next = S_START;
      S_START:  w_next = (SETTLE_CYC == 0) ? S_WAIT : S_SETTLE;
      S_SETTLE: if (r_cnt == C_CNT_LAST) w_next = S_WAIT;
      S_WAIT:   if (w_layer_done) w_next = (r_idx == r_last) ? S_DONE : S_FETCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // Abort wins over run and completion.
    if (abort_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) r_tbl[i] <= '0;
      r_last      <= '0;
      r_idx       <= '0;
      r_rd_seen   <= 1'b0;
      r_proc_seen <= 1'b0;
      r_cnt       <= '0;
      r_start     <= 1'b0;
      r_exp_en    <= 1'b0;
      r_limit     <= '0;
      r_depth     <= '0;
      r_dim       <= '0;
      r_busy      <= 1'b0;
      r_all_done  <= 1'b0;
    end else begin
      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      r_start    <= (w_next == S_START);
      r_all_done <= (w_next == S_DONE);
      r_busy     <= (w_next != S_IDLE);

      if ((r_state == S_IDLE) && cfg_wr_en_i) begin
        r_tbl[cfg_wr_addr_i] <= cfg_wr_data_i;
      end

      if ((r_state == S_IDLE) && (w_next == S_FETCH)) begin
        r_last <= num_layers_i;
        r_idx  <= '0;
      end

      // Config is only loaded when FETCH really proceeds, so an abort
      // during FETCH leaves the previous layer's config on the outputs.
      if ((r_state == S_FETCH) && (w_next == S_START)) begin
        r_exp_en <= r_tbl[r_idx][20];
        r_limit  <= r_tbl[r_idx][19:13];
        r_depth  <= r_tbl[r_idx][12:7];
        r_dim    <= r_tbl[r_idx][6:0];
      end

      if ((r_state == S_WAIT) && (w_next == S_FETCH)) begin
        r_idx <= r_idx + 3'd1;
      end

      case (r_state)
        S_START: begin
          r_rd_seen   <= 1'b0;
          r_proc_seen <= 1'b0;
          r_cnt       <= '0;
        end
        S_SETTLE: begin
          // rd_done_i is deliberately not sampled during the settle window.
          if (proc_done_i) r_proc_seen <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
        end
        S_WAIT: begin
          if (rd_done_i)   r_rd_seen   <= 1'b1;
          if (proc_done_i) r_proc_seen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign start_o                   = r_start;
  assign exp_1x1_en_o              = r_exp_en;
  assign one_exp1_ker_addr_limit_o = r_limit;
  assign exp1_ker_depth_o          = r_depth;
  assign layer_dimension_o         = r_dim;
  assign layer_idx_o               = r_idx;
  assign busy_o                    = r_busy;
  assign all_done_o                = r_all_done;

endmodule

`default_nettype wire

// File: doc/fire_layer_sequencer.md
FIRE_LAYER_SEQUENCER -- requirements
Module: fire_layer_sequencer

Interface
REQ-001 SHALL have parameter: SETTLE_CYC, default 3, number of cycles after start_o during which completion is not sampled.
REQ-002 SHALL have ports:
- clk_i  in  1  the only clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cfg_wr_en_i  in  1  config table write strobe.
- cfg_wr_addr_i  in  3  table entry index 0-7.
- cfg_wr_data_i  in  21  entry: [20] exp_1x1_en, [19:13] kernel address limit, [12:7] depth-1, [6:0] dimension-1.
- num_layers_i  in  3  number of layers to run, minus 1; sampled with run_i.
- run_i  in  1  start-of-sequence pulse.
- abort_i  in  1  abandon the sequence.
- rd_done_i  in  1  level: kernel reader finished the current layer.
- proc_done_i  in  1  pulse: compute path finished the current layer.
- start_o  out  1  one-cycle layer start to the kernel reader.
- exp_1x1_en_o  out  1  current layer expand-1x1 enable.
- one_exp1_ker_addr_limit_o  out  7  current layer address limit.
- exp1_ker_depth_o  out  6  current layer depth-1.
- layer_dimension_o  out  7  current layer dimension-1.
- layer_idx_o  out  3  index of the current layer.
- busy_o  out  1  high in every state except IDLE.
- all_done_o  out  1  one-cycle pulse when the last layer completes.

Function
REQ-003 SHALL hold an 8x21-bit register table; cfg_wr_en_i writes cfg_wr_data_i to entry cfg_wr_addr_i only while in IDLE; writes in any other state are dropped.
REQ-004 SHALL implement FSM states IDLE, FETCH, START, SETTLE, WAIT, DONE, all with registered outputs.
REQ-005 IDLE: run_i=1 -> latch num_layers_i as the last index, clear layer_idx_o to 0, go to FETCH; a run_i outside IDLE SHALL be ignored.
REQ-006 FETCH: load table[layer_idx_o] onto the four config outputs, go to START; config outputs SHALL then hold until the next FETCH.
REQ-007 START: start_o=1 for exactly this cycle; clear the sticky flags rd_seen and proc_seen; go to SETTLE.
REQ-008 SETTLE: count SETTLE_CYC cycles, then go to WAIT; rd_done_i ignored; a proc_done_i pulse SHALL set proc_seen.
REQ-009 WAIT: rd_done_i=1 sets rd_seen; proc_done_i=1 sets proc_seen; the layer is complete when proc_seen and (rd_seen or exp_1x1_en_o=0), with the same-cycle input value counting.
REQ-010 On layer complete: if layer_idx_o equals the last index go to DONE, else increment layer_idx_o and go to FETCH.
REQ-011 DONE: all_done_o=1 for one cycle, go to IDLE.
REQ-012 Latency: run_i sampled at cycle N -> start_o high at N+2; layer complete at cycle M -> next start_o at M+2.
REQ-013 abort_i=1 in any state SHALL go to IDLE next cycle: no all_done_o, start_o low, and the table and config outputs retained; abort_i has priority over run_i and completion in the same cycle.
REQ-014 num_layers_i=7 SHALL run all 8 entries; layer_idx_o SHALL never wrap within a sequence.

Reset
REQ-015 rst_i=1 SHALL return the FSM to IDLE and clear every output, layer_idx_o, the sticky flags, the settle counter and all table entries to 0, overriding all other inputs.

Verification
REQ-016 Table entry 0 = {1,16,5,12}, num_layers_i=0, then run_i -> start_o at run+2 with outputs 1/16/5/12; rd_done_i then proc_done_i -> all_done_o one cycle, busy_o low after it.
REQ-017 3 layers, entry 1 with exp_1x1_en=0 -> layer 1 completes on proc_done_i alone; layer_idx_o steps 0,1,2; exactly 3 start_o pulses.
REQ-018 proc_done_i pulsed in SETTLE, rd_done_i arrives later in WAIT -> layer completes on the rd_done_i cycle; rd_done_i held high during SETTLE alone -> no completion.
REQ-019 abort_i during WAIT of layer 1 -> IDLE next cycle, no all_done_o; a new run_i restarts at layer 0.
REQ-020 cfg write and run_i issued while busy -> table unchanged, sequence unaffected; rst_i mid-WAIT -> all outputs 0 the following cycle.
